// File: rtl/siso_input_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : siso_input_demux_pkg
// Description : Shared definitions for the SISO input demultiplexer.
//               Provides the branch storage geometry (BRANCH_SIZE, AW), the
//               trellis-step counter width, the FSM state encoding and the
//               block-length legality check used on i_start.
// Revision    : 1.0 - initial release
// ============================================================================
package siso_input_demux_pkg;

    // Largest code block in trellis steps. Port and counter widths derive
    // from it, so the top-level BLKLEN_MAX parameter defaults to this value.
    localparam int c_BLKLEN_MAX_DEF = 6144;

    // Each branch stores half of the steps (even or odd indices).
    localparam int BRANCH_SIZE = c_BLKLEN_MAX_DEF / 2;
    localparam int AW          = $clog2(BRANCH_SIZE);

    // Width of the trellis-step counter k.
    localparam int c_KW = $clog2(c_BLKLEN_MAX_DEF);

    // FSM state encoding.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SYS  = 2'd1;
    localparam logic [1:0] c_ST_PAR  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // A block length is legal when it is even, at least 2 and not larger
    // than the branch storage can hold.
    function automatic logic is_valid_blklen(input logic [31:0] len,
                                             input logic [31:0] len_max);
        return (len[0] == 1'b0) && (len >= 32'd2) && (len <= len_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/siso_branch_writer.sv
`default_nettype none
// ============================================================================
// Module      : siso_branch_writer
// Description : Registered write ports towards the branch1/branch2 storage.
//               A step strobe with step index k writes (sys, parity) to
//               branch1 when k is even and to branch2 when k is odd, at
//               address k>>1. Only the selected branch updates its data and
//               address; the other branch holds its last values.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_step_valid        - one complete (sys, parity) step
//               i_k                 - trellis step index of that step
//               i_sys, i_parity     - soft words of the step
//               o_branch{1,2}_*     - sys, parity, addr, wrvalid per branch
// Revision    : 1.0 - initial release
// ============================================================================
module siso_branch_writer
    import siso_input_demux_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step_valid,
    input  logic [c_KW-1:0]   i_k,
    input  logic [DWIDTH-1:0] i_sys,
    input  logic [DWIDTH-1:0] i_parity,
    output logic [DWIDTH-1:0] o_branch1_sys,
    output logic [DWIDTH-1:0] o_branch1_parity,
    output logic [AW-1:0]     o_branch1_addr,
    output logic              o_branch1_wrvalid,
    output logic [DWIDTH-1:0] o_branch2_sys,
    output logic [DWIDTH-1:0] o_branch2_parity,
    output logic [AW-1:0]     o_branch2_addr,
    output logic              o_branch2_wrvalid
);

    logic              w_wr_b1;
    logic              w_wr_b2;
    logic [AW-1:0]     w_addr;

    logic [DWIDTH-1:0] r_b1_sys;
    logic [DWIDTH-1:0] r_b1_parity;
    logic [AW-1:0]     r_b1_addr;
    logic              r_b1_wrvalid;
    logic [DWIDTH-1:0] r_b2_sys;
    logic [DWIDTH-1:0] r_b2_parity;
    logic [AW-1:0]     r_b2_addr;
    logic              r_b2_wrvalid;

    // k[0] selects the branch; the remaining bits are the branch address.
    assign w_wr_b1 = i_step_valid & ~i_k[0];
    assign w_wr_b2 = i_step_valid &  i_k[0];
    assign w_addr  = AW'(i_k >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b1_sys     <= '0;
            r_b1_parity  <= '0;
            r_b1_addr    <= '0;
            r_b1_wrvalid <= 1'b0;
            r_b2_sys     <= '0;
            r_b2_parity  <= '0;
            r_b2_addr    <= '0;
            r_b2_wrvalid <= 1'b0;
        end else begin
            r_b1_wrvalid <= w_wr_b1;
            r_b2_wrvalid <= w_wr_b2;
            if (w_wr_b1) begin
                r_b1_sys    <= i_sys;
                r_b1_parity <= i_parity;
                r_b1_addr   <= w_addr;
            end
            if (w_wr_b2) begin
                r_b2_sys    <= i_sys;
                r_b2_parity <= i_parity;
                r_b2_addr   <= w_addr;
            end
        end
    end

    assign o_branch1_sys     = r_b1_sys;
    assign o_branch1_parity  = r_b1_parity;
    assign o_branch1_addr    = r_b1_addr;
    assign o_branch1_wrvalid = r_b1_wrvalid;
    assign o_branch2_sys     = r_b2_sys;
    assign o_branch2_parity  = r_b2_parity;
    assign o_branch2_addr    = r_b2_addr;
    assign o_branch2_wrvalid = r_b2_wrvalid;

endmodule
`default_nettype wire

// File: rtl/siso_input_demux.sv
`default_nettype none
// ============================================================================
// Module      : siso_input_demux
// Description : Input stage ahead of the SISO decoder branch storage. Takes
//               one code block as alternating sys/parity words, routes even
//               trellis steps to branch1 and odd steps to branch2 at address
//               k>>1, signals completion and flags config/framing errors.
// Ports       : aclk, areset        - clock, synchronous active-high reset
//               i_start, blklen     - start pulse and block length (steps)
//               s_axis_in_*         - soft-word input stream
//               branch{1,2}_*       - registered branch write ports
//               o_busy, o_done      - block in progress / last write issued
//               o_cfg_err           - start rejected (bad blklen)
//               o_tlast_err         - tlast does not match the step counter
// Revision    : 1.0 - initial release
// ============================================================================
module siso_input_demux
    import siso_input_demux_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int BLKLEN_MAX = c_BLKLEN_MAX_DEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              i_start,
    input  logic [DWIDTH-1:0] blklen,
    input  logic [DWIDTH-1:0] s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    output logic              s_axis_in_tready,
    input  logic              s_axis_in_tlast,
    output logic [DWIDTH-1:0] branch1_sys,
    output logic [DWIDTH-1:0] branch1_parity,
    output logic [AW-1:0]     branch1_addr,
    output logic              branch1_wrvalid,
    output logic [DWIDTH-1:0] branch2_sys,
    output logic [DWIDTH-1:0] branch2_parity,
    output logic [AW-1:0]     branch2_addr,
    output logic              branch2_wrvalid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic              o_tlast_err
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [c_KW-1:0]   r_k;
    logic [c_KW-1:0]   r_last_k;
    logic [DWIDTH-1:0] r_sys_hold;

    logic              r_tready;
    logic              r_busy;
    logic              r_done;
    logic              r_cfg_err;
    logic              r_tlast_err;

    logic              w_tready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_cfg_err_nxt;
    logic              w_tlast_err_nxt;

    logic              w_hs;
    logic              w_sys_hs;
    logic              w_par_hs;
    logic              w_is_last;
    logic              w_start_req;
    logic              w_len_ok;
    logic              w_start_ok;

    assign w_hs        = s_axis_in_tvalid & r_tready;
    assign w_sys_hs    = w_hs & (r_state == c_ST_SYS);
    assign w_par_hs    = w_hs & (r_state == c_ST_PAR);
    // r_last_k holds blklen-1 truncated to the counter width; the range
    // check at start guarantees the truncation loses nothing.
    assign w_is_last   = (r_k == r_last_k);
    assign w_start_req = i_start & (r_state == c_ST_IDLE);
    assign w_len_ok    = is_valid_blklen(32'(blklen), 32'(BLKLEN_MAX));
    assign w_start_ok  = w_start_req & w_len_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_ok) w_state_next = c_ST_SYS;
            c_ST_SYS:  if (w_sys_hs)   w_state_next = c_ST_PAR;
            c_ST_PAR:  if (w_par_hs)   w_state_next = w_is_last ? c_ST_DONE : c_ST_SYS;
            c_ST_DONE:                 w_state_next = c_ST_IDLE;
            default:                   w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt      = 1'b0;
        w_tready_nxt    = (w_state_next == c_ST_SYS) || (w_state_next == c_ST_PAR);
        // o_done lands in the same cycle as the final write, both being
        // registered off the final parity handshake.
        w_done_nxt      = w_par_hs & w_is_last;
        w_cfg_err_nxt   = w_start_req & ~w_len_ok;
        // tlast is only reported; the step counter alone ends the block.
        w_tlast_err_nxt = (w_sys_hs & s_axis_in_tlast)
                        | (w_par_hs & (s_axis_in_tlast != w_is_last));
        case (r_state)
            c_ST_IDLE: w_busy_nxt = w_start_ok;
            c_ST_SYS:  w_busy_nxt = 1'b1;
            c_ST_PAR:  w_busy_nxt = 1'b1;
            c_ST_DONE: w_busy_nxt = 1'b0;
            default:   w_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_tlast_err <= 1'b0;
        end else begin
            r_tready    <= w_tready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
            r_tlast_err <= w_tlast_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Step counter, latched length and sys holding register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_k        <= '0;
            r_last_k   <= '0;
            r_sys_hold <= '0;
        end else begin
            if (w_start_ok) begin
                r_k      <= '0;
                r_last_k <= c_KW'(blklen - DWIDTH'(1));
            end else if (w_par_hs && !w_is_last) begin
                r_k <= r_k + c_KW'(1);
            end
            if (w_sys_hs) begin
                r_sys_hold <= s_axis_in_tdata;
            end
        end
    end

    siso_branch_writer #(
        .DWIDTH (DWIDTH)
    ) u_branch_writer (
        .clk               (aclk),
        .rst               (areset),
        .i_step_valid      (w_par_hs),
        .i_k               (r_k),
        .i_sys             (r_sys_hold),
        .i_parity          (s_axis_in_tdata),
        .o_branch1_sys     (branch1_sys),
        .o_branch1_parity  (branch1_parity),
        .o_branch1_addr    (branch1_addr),
        .o_branch1_wrvalid (branch1_wrvalid),
        .o_branch2_sys     (branch2_sys),
        .o_branch2_parity  (branch2_parity),
        .o_branch2_addr    (branch2_addr),
        .o_branch2_wrvalid (branch2_wrvalid)
    );

    assign s_axis_in_tready = r_tready;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_cfg_err        = r_cfg_err;
    assign o_tlast_err      = r_tlast_err;

endmodule
`default_nettype wire

// File: tb/tb_siso_input_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_siso_input_demux
// Description : Self-checking bench for siso_input_demux. Drives directed
//               and randomized blocks; the expected branch writes, their
//               cycle of appearance and the tlast error pulses are computed
//               from the block contents and the inserted tvalid gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_siso_input_demux;
    import siso_input_demux_pkg::*;

    localparam int c_DW   = 16;
    localparam int c_MAXW = 2 * 6144;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            i_start = 1'b0;
    logic [c_DW-1:0] blklen = '0;
    logic [c_DW-1:0] s_axis_in_tdata = '0;
    logic            s_axis_in_tvalid = 1'b0;
    logic            s_axis_in_tready;
    logic            s_axis_in_tlast = 1'b0;
    logic [c_DW-1:0] branch1_sys, branch1_parity, branch2_sys, branch2_parity;
    logic [AW-1:0]   branch1_addr, branch2_addr;
    logic            branch1_wrvalid, branch2_wrvalid;
    logic            o_busy, o_done, o_cfg_err, o_tlast_err;

    siso_input_demux #(.DWIDTH(c_DW), .BLKLEN_MAX(6144)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .i_start          (i_start),
        .blklen           (blklen),
        .s_axis_in_tdata  (s_axis_in_tdata),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .s_axis_in_tready (s_axis_in_tready),
        .s_axis_in_tlast  (s_axis_in_tlast),
        .branch1_sys      (branch1_sys),
        .branch1_parity   (branch1_parity),
        .branch1_addr     (branch1_addr),
        .branch1_wrvalid  (branch1_wrvalid),
        .branch2_sys      (branch2_sys),
        .branch2_parity   (branch2_parity),
        .branch2_addr     (branch2_addr),
        .branch2_wrvalid  (branch2_wrvalid),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_cfg_err        (o_cfg_err),
        .o_tlast_err      (o_tlast_err)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed {
        logic            br;
        logic [c_DW-1:0] sys;
        logic [c_DW-1:0] par;
        logic [AW-1:0]   addr;
        logic            done;
        logic            terr;
        logic [31:0]     cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  exp_terr[$];
    int  obs_terr[$];
    wr_t mon_w;
    wr_t e_w;

    int n_checks = 0;
    int n_errors = 0;
    int n_both = 0;
    int n_stray_done = 0;
    int n_cfg_obs = 0;
    int n_cfg_exp = 0;

    logic [c_DW-1:0] wd [c_MAXW];
    logic            tl [c_MAXW];
    int              gp [c_MAXW];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic finish_all();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Passive monitor: writes and standalone pulses, sampled mid-cycle.
    always @(negedge aclk) begin
        if (branch1_wrvalid || branch2_wrvalid) begin
            mon_w.br   = branch2_wrvalid;
            mon_w.sys  = branch2_wrvalid ? branch2_sys    : branch1_sys;
            mon_w.par  = branch2_wrvalid ? branch2_parity : branch1_parity;
            mon_w.addr = branch2_wrvalid ? branch2_addr   : branch1_addr;
            mon_w.done = o_done;
            mon_w.terr = o_tlast_err;
            mon_w.cyc  = cyc;
            obs_q.push_back(mon_w);
        end else begin
            if (o_done) n_stray_done++;
            if (o_tlast_err) obs_terr.push_back(cyc);
        end
        if (branch1_wrvalid && branch2_wrvalid) n_both++;
        if (o_cfg_err) n_cfg_obs++;
    end

    task automatic compare_block();
        int n;
        check_val("n_writes", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val("wr_branch", obs_q[i].br,   exp_q[i].br);
            check_val("wr_sys",    obs_q[i].sys,  exp_q[i].sys);
            check_val("wr_parity", obs_q[i].par,  exp_q[i].par);
            check_val("wr_addr",   obs_q[i].addr, exp_q[i].addr);
            check_val("wr_done",   obs_q[i].done, exp_q[i].done);
            check_val("wr_tlast_err", obs_q[i].terr, exp_q[i].terr);
            check_val("wr_cycle",  obs_q[i].cyc,  exp_q[i].cyc);
        end
        check_val("n_sys_tlast_err", obs_terr.size(), exp_terr.size());
        n = (obs_terr.size() < exp_terr.size()) ? obs_terr.size() : exp_terr.size();
        for (int i = 0; i < n; i++) check_val("sys_tlast_err_cycle", obs_terr[i], exp_terr[i]);
        exp_q.delete();
        obs_q.delete();
        exp_terr.delete();
        obs_terr.delete();
    endtask

    task automatic start_block(input int len, output bit acc);
        acc = (len % 2 == 0) && (len >= 2) && (len <= 6144);
        blklen  = 16'(len);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_val("start_busy",   o_busy,           acc);
        check_val("start_tready", s_axis_in_tready, acc);
        check_val("start_cfg_err", o_cfg_err,       !acc);
        if (!acc) begin
            n_cfg_exp++;
            tick();
            check_val("cfg_err_pulse_end", o_cfg_err, 0);
            check_val("cfg_busy",   o_busy, 0);
            check_val("cfg_tready", s_axis_in_tready, 0);
        end
    endtask

    // tmode: 0 tlast correct, 1 extra tlast on word 4, 2 tlast missing on
    //        last word, 3 random flips, 4 tlast on word 3 (a sys beat)
    // gmode: 0 no gaps, 1 three idle cycles before word 2, 2 random gaps
    task automatic run_block(input int len, input int tmode, input int gmode,
                             input int abort_at, input bit start_in_done, input bit seq_data);
        int nw;
        int sc;
        int gsum;
        int k;
        bit acc;
        bit got;
        nw = 2 * len;
        for (int j = 0; j < nw && j < c_MAXW; j++) begin
            wd[j] = seq_data ? 16'(j + 1) : 16'($urandom);
            tl[j] = (j == nw - 1);
            gp[j] = 0;
            if (gmode == 2 && $urandom_range(0, 3) == 0) gp[j] = $urandom_range(1, 3);
            if (tmode == 3 && $urandom_range(0, 7) == 0) tl[j] = !tl[j];
        end
        if (gmode == 1 && nw > 1) gp[1] = 3;
        if (tmode == 1 && nw > 3) tl[3] = 1'b1;
        if (tmode == 2 && nw > 0 && nw <= c_MAXW) tl[nw-1] = 1'b0;
        if (tmode == 4 && nw > 2) tl[2] = 1'b1;

        start_block(len, acc);
        if (!acc) return;
        sc   = cyc;
        gsum = 0;
        for (int j = 0; j < nw; j++) begin
            if (abort_at >= 0 && j == abort_at) break;
            s_axis_in_tvalid = 1'b0;
            repeat (gp[j]) tick();
            gsum += gp[j];
            s_axis_in_tdata  = wd[j];
            s_axis_in_tlast  = tl[j];
            s_axis_in_tvalid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 64 && !got; t++) begin
                @(negedge aclk);
                got = s_axis_in_tready;
                @(posedge aclk);
                #1;
            end
            if (!got) begin
                check_val("handshake_timeout", 0, 1);
                finish_all();
            end
            k = j / 2;
            if (j % 2 == 0) begin
                if (tl[j]) exp_terr.push_back(sc + gsum + j + 1);
            end else begin
                e_w.br   = 1'(k % 2);
                e_w.sys  = wd[j-1];
                e_w.par  = wd[j];
                e_w.addr = AW'(k / 2);
                e_w.done = (k == len - 1);
                e_w.terr = (tl[j] != (k == len - 1));
                e_w.cyc  = sc + gsum + j + 1;
                exp_q.push_back(e_w);
            end
        end
        s_axis_in_tvalid = 1'b0;
        s_axis_in_tlast  = 1'b0;
        if (abort_at >= 0) begin
            areset = 1'b1;
            tick();
            areset = 1'b0;
            check_val("abort_tready", s_axis_in_tready, 0);
            check_val("abort_busy",   o_busy, 0);
            repeat (4) tick();
            check_val("abort_idle_busy", o_busy, 0);
        end else begin
            // Final write cycle.
            check_val("done_pulse",  o_done, 1);
            check_val("done_busy",   o_busy, 1);
            check_val("done_tready", s_axis_in_tready, 0);
            if (start_in_done) begin
                blklen  = 16'(len);
                i_start = 1'b1;
            end
            tick();
            i_start = 1'b0;
            check_val("idle_done",   o_done, 0);
            check_val("idle_busy",   o_busy, 0);
            check_val("idle_tready", s_axis_in_tready, 0);
            if (start_in_done) begin
                tick();
                check_val("ignored_start_busy", o_busy, 0);
            end
        end
        compare_block();
    endtask

    initial begin
        // Reset state
        areset = 1'b1;
        repeat (3) tick();
        check_val("rst_tready", s_axis_in_tready, 0);
        check_val("rst_busy",   o_busy, 0);
        check_val("rst_flags",  {o_done, o_cfg_err, o_tlast_err, branch1_wrvalid, branch2_wrvalid}, 0);
        check_val("rst_b1_data", {branch1_sys, branch1_parity}, 0);
        check_val("rst_b2_data", {branch2_sys, branch2_parity}, 0);
        check_val("rst_addr",    {branch1_addr, branch2_addr}, 0);
        areset = 1'b0;
        tick();

        // Nominal block, words 1..8
        run_block(4, 0, 0, -1, 0, 1);
        // Gap of three cycles between sys and parity
        run_block(2, 0, 1, -1, 0, 1);
        // Config errors, then the maximum length is accepted later
        run_block(5, 0, 0, -1, 0, 1);
        run_block(0, 0, 0, -1, 0, 1);
        run_block(6146, 0, 0, -1, 0, 1);
        // Framing errors
        run_block(4, 1, 0, -1, 0, 1);
        run_block(4, 2, 0, -1, 0, 1);
        run_block(4, 4, 0, -1, 0, 1);
        // Reset mid-block after five words, then a fresh short block
        run_block(6, 0, 0, 5, 0, 1);
        run_block(2, 0, 0, -1, 0, 1);
        // Back-to-back with a start pulse during DONE
        run_block(2, 0, 0, -1, 1, 1);
        run_block(2, 0, 0, -1, 0, 1);
        // Randomized blocks
        for (int b = 0; b < 12; b++) begin
            run_block(2 * $urandom_range(1, 16),
                      ($urandom_range(0, 2) == 0) ? 3 : 0,
                      2, -1, 1'($urandom_range(0, 1)), 0);
        end
        run_block(2 * $urandom_range(0, 20) + 1, 0, 0, -1, 0, 0);
        // Largest legal block
        run_block(6144, 0, 0, -1, 0, 0);

        repeat (3) tick();
        check_val("both_wrvalid_cycles", n_both, 0);
        check_val("stray_done_pulses",   n_stray_done, 0);
        check_val("cfg_err_pulses",      n_cfg_obs, n_cfg_exp);
        finish_all();
    end

endmodule
`default_nettype wire

// File: doc/siso_input_demux.md
Name: siso_input_demux

Overview:
- Input stage directly upstream of the SISO decoder's branch1/branch2 storage.
- Accepts one code block of soft bits over an AXI-Stream-style input, as alternating sys/parity words per trellis step.
- Splits the steps by parity of index: even steps go to the branch 1 write port, odd steps to the branch 2 write port, each at address k>>1.
- Signals block completion, and flags configuration and framing errors.

Parameters:
DWIDTH, 16, width of one soft-bit word and of blklen
BLKLEN_MAX, 6144, maximum trellis steps per block; BRANCH_SIZE = BLKLEN_MAX/2, AW = $clog2(BRANCH_SIZE)

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
i_start  in  1  one-cycle pulse; latch blklen and begin a block (honoured in IDLE only)
blklen  in  DWIDTH  trellis steps in the block, sampled on i_start
s_axis_in_tdata  in  DWIDTH  soft word: sys, parity, sys, parity...
s_axis_in_tvalid  in  1  input word valid
s_axis_in_tready  out  1  input word accepted when valid&ready
s_axis_in_tlast  in  1  marks the final parity word of the block
branch1_sys  out  DWIDTH  sys word, even step
branch1_parity  out  DWIDTH  parity word, even step
branch1_addr  out  AW  k>>1 for even k
branch1_wrvalid  out  1  one-cycle write strobe
branch2_sys / branch2_parity / branch2_addr / branch2_wrvalid  out  DWIDTH/DWIDTH/AW/1  same, odd steps
o_busy  out  1  high from accepted start until o_done
o_done  out  1  one-cycle pulse, last write issued
o_cfg_err  out  1  one-cycle pulse, start rejected
o_tlast_err  out  1  one-cycle pulse, framing mismatch

Behaviour:
- All outputs are registered. Reset value of every output is 0; reset also clears the state to IDLE, the step counter and the latched length.
- Reset has priority over everything. Reset mid-block drops the partial block: no further writes, and no o_done.
- FSM states: IDLE, SYS, PAR, DONE.
- IDLE, tready=0:
  - On i_start, check blklen: it must be even, >=2 and <=BLKLEN_MAX.
  - Valid: latch blklen, clear step counter k, set o_busy, go to SYS.
  - Invalid: pulse o_cfg_err next cycle, stay IDLE.
- SYS, tready=1: on handshake, capture the word into a sys holding register and go to PAR.
- PAR, tready=1: on handshake, capture the parity word.
  - Next cycle, assert wrvalid on the branch selected by k[0] (0 = branch1, 1 = branch2), with the held sys, the parity and addr=k>>1.
  - Only one wrvalid is high in any cycle. The other branch's data/addr outputs hold their last values.
  - If k==blklen-1, go to DONE; otherwise k<=k+1 and go to SYS.
- DONE, tready=0: o_done=1 for one cycle, in the same cycle as the final wrvalid. Then clear o_busy and return to IDLE.
- Latency: wrvalid appears exactly 1 cycle after the parity handshake.
- Throughput: one word per cycle; one step per 2 cycles with tvalid held high.
- tvalid gaps stall the FSM. No write occurs during a gap.
- tlast checking:
  - Sampled on every parity handshake. If tlast=1 on a parity beat with k!=blklen-1, or tlast=0 on the final parity beat, pulse o_tlast_err with that beat's write.
  - tlast on a sys beat also pulses o_tlast_err.
  - Block length is governed by the counter only; the error is reported, never used to terminate.
- i_start outside IDLE is ignored, with no error.
- A new i_start is accepted on the cycle after DONE, so back-to-back blocks have a 2-cycle gap with tready low.
- Counter k is $clog2(BLKLEN_MAX) bits wide; the comparison is against the latched blklen truncated to that width, after the range check.

Decomposition:
- Shared package: localparams BRANCH_SIZE and AW, the FSM state encoding, and a function is_valid_blklen(len, max).
- One sub-module is natural: siso_branch_writer. It takes a step-valid strobe, k, sys and parity, and produces the registered branch1/branch2 write ports. The FSM stays in the top level.

Test Plan:
- Nominal block: blklen=4, words 1..8 with tvalid constant, tlast on word 8.
  - branch1 writes (sys=1,par=2,addr=0) and (5,6,1).
  - branch2 writes (3,4,0) and (7,8,1).
  - o_done coincides with the last write; o_tlast_err never pulses.
- Backpressure gaps: blklen=2, with tvalid dropped for 3 cycles between sys and parity.
  - Writes are identical to the gap-free run, delayed by 3 cycles.
  - No spurious wrvalid during the gap.
- Config errors: blklen=5, 0 and 6146 each give one o_cfg_err pulse each, with tready=0 and o_busy=0 throughout.
  - blklen=6144 is accepted.
- Framing: blklen=4 with tlast on word 4 → o_tlast_err pulses with the branch2 addr=0 write; the block still completes 4 writes.
  - tlast absent on word 8 → o_tlast_err on the final write.
- Reset mid-block: blklen=6, assert areset after 5 words.
  - Next cycle: tready=0, o_busy=0, no further writes.
  - A fresh blklen=2 block then produces branch1 addr=0 and branch2 addr=0 only.
- Back-to-back: blklen=2 blocks with i_start pulsed during DONE (ignored), then pulsed again 2 cycles later.
  - The second start is accepted; addresses restart at 0.
